// File: rtl/dl_path_pkg.sv
// Shared downlink-path constants: IQ field layout, measurement FSM encoding
// and the input-to-result latency of the antenna power meter.
package dl_path_pkg;

  localparam int XNUM_DEF = 4;

  localparam int I_MSB = 31;
  localparam int I_LSB = 16;
  localparam int Q_MSB = 15;
  localparam int Q_LSB = 0;

  // Edges from sampling the last window input to the published result.
  localparam int POW_LAT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dl_pow_sq.sv
// Two-stage registered I^2+Q^2 for one 32-bit IQ sample; the valid flag and
// an opaque tag travel alongside so the caller can route the result.
module dl_pow_sq
  import dl_path_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             syn_rst_n,
  input  logic             i_vld,
  input  logic [31:0]      i_iq,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_vld,
  output logic [31:0]      o_pow,
  output logic [TAG_W-1:0] o_tag
);

  logic signed [30:0] i_ext, q_ext;
  logic               s1_vld_q, s1_vld_d;
  logic [30:0]        isq_q, isq_d, qsq_q, qsq_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
  logic               s2_vld_q, s2_vld_d;
  logic [31:0]        sum_q, sum_d;
  logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;

  // Sign-extend to 31 bits: the largest square, (-32768)^2 = 2^30, still fits.
  always_comb begin
    i_ext    = {{15{i_iq[I_MSB]}}, i_iq[I_MSB:I_LSB]};
    q_ext    = {{15{i_iq[Q_MSB]}}, i_iq[Q_MSB:Q_LSB]};
    s1_vld_d = i_vld;
    isq_d    = i_ext * i_ext;
    qsq_d    = q_ext * q_ext;
    s1_tag_d = i_tag;
    s2_vld_d = s1_vld_q;
    sum_d    = {1'b0, isq_q} + {1'b0, qsq_q};
    s2_tag_d = s1_tag_q;
  end

  always_ff @(posedge clk) begin
    if (!syn_rst_n) begin
      s1_vld_q <= 1'b0;
      isq_q    <= '0;
      qsq_q    <= '0;
      s1_tag_q <= '0;
      s2_vld_q <= 1'b0;
      sum_q    <= '0;
      s2_tag_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      isq_q    <= isq_d;
      qsq_q    <= qsq_d;
      s1_tag_q <= s1_tag_d;
      s2_vld_q <= s2_vld_d;
      sum_q    <= sum_d;
      s2_tag_q <= s2_tag_d;
    end
  end

  assign o_vld = s2_vld_q;
  assign o_pow = sum_q;
  assign o_tag = s2_tag_q;

endmodule

// File: rtl/dl_ant_pow_meas.sv
// Per-antenna mean power over 2^WIN_LOG2 rounds of the antenna-interleaved
// downlink stream; all XNUM means are published together with a valid pulse.
module dl_ant_pow_meas
  import dl_path_pkg::*;
#(
  parameter int XNUM     = XNUM_DEF,
  parameter int WIN_LOG2 = 10
) (
  input  logic              clk,
  input  logic              syn_rst_n,
  input  logic              i_meas_en,
  input  logic              i_fram_hd,
  input  logic [31:0]       i_data,
  input  logic              i_data_valid,
  output logic [XNUM*32-1:0] o_pow,
  output logic              o_meas_valid,
  output logic [15:0]       o_win_cnt,
  output logic              o_busy
);

  localparam int SW    = (XNUM > 1) ? $clog2(XNUM) : 1;
  localparam int AW    = 32 + WIN_LOG2;
  localparam int TAG_W = SW + 2;
  localparam logic [SW-1:0] SLOT_LAST = SW'(XNUM - 1);

  state_e                    state_q, state_d;
  logic [SW-1:0]             slot_q, slot_d, eff_slot;
  logic [WIN_LOG2-1:0]       smp_q, smp_d, eff_smp;
  logic                      hd, accept, is_last, is_first;
  logic                      in_v_q, in_v_d;
  logic [31:0]               in_data_q, in_data_d;
  logic [TAG_W-1:0]          in_tag_q, in_tag_d;
  logic                      sq_v;
  logic [31:0]               sq_pow;
  logic [TAG_W-1:0]          sq_tag;
  logic [XNUM-1:0][AW-1:0]   acc_q, acc_d;
  logic                      pub_q, pub_d;
  logic [XNUM*32-1:0]        pow_q, pow_d;
  logic                      mv_q, mv_d;
  logic [15:0]               wcnt_q, wcnt_d;

  // Tag layout: {last, first, slot}. A frame head forces slot 0 / sample 0,
  // so a head on what would be the last sample can never be tagged last.
  always_comb begin
    hd       = i_data_valid & i_fram_hd;
    eff_slot = hd ? '0 : slot_q;
    eff_smp  = hd ? '0 : smp_q;
    is_last  = (eff_slot == SLOT_LAST) && (&eff_smp);
    is_first = (eff_slot == '0) && (eff_smp == '0);
    accept   = 1'b0;
    state_d  = state_q;
    slot_d   = slot_q;
    smp_d    = smp_q;
    unique case (state_q)
      ST_IDLE: begin
        slot_d = '0;
        smp_d  = '0;
        accept = hd & i_meas_en;
        if (accept) state_d = ST_ACC;
      end
      ST_ACC: begin
        if (!i_meas_en) state_d = ST_IDLE;
        else            accept  = i_data_valid;
        if (accept && is_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        accept = i_data_valid & i_meas_en;
        if (pub_q) state_d = i_meas_en ? ST_ACC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      if (eff_slot == SLOT_LAST) begin
        slot_d = '0;
        smp_d  = eff_smp + 1'b1;
      end else begin
        slot_d = eff_slot + 1'b1;
        smp_d  = eff_smp;
      end
    end
    in_v_d    = accept;
    in_data_d = i_data;
    in_tag_d  = {is_last && (state_q == ST_ACC), is_first, eff_slot};
  end

  dl_pow_sq #(
    .TAG_W (TAG_W)
  ) u_pow_sq (
    .clk       (clk),
    .syn_rst_n (syn_rst_n),
    .i_vld     (in_v_q),
    .i_iq      (in_data_q),
    .i_tag     (in_tag_q),
    .o_vld     (sq_v),
    .o_pow     (sq_pow),
    .o_tag     (sq_tag)
  );

  // A first-tagged sample wipes leftovers of any aborted window before adding.
  always_comb begin
    acc_d = acc_q;
    pub_d = 1'b0;
    if (state_q == ST_IDLE || pub_q) acc_d = '0;
    if (sq_v && state_q != ST_IDLE) begin
      if (sq_tag[SW]) acc_d = '0;
      acc_d[sq_tag[SW-1:0]] = acc_d[sq_tag[SW-1:0]] + {{WIN_LOG2{1'b0}}, sq_pow};
      pub_d = sq_tag[SW+1];
    end
    pow_d  = pow_q;
    mv_d   = 1'b0;
    wcnt_d = wcnt_q;
    if (pub_q) begin
      for (int k = 0; k < XNUM; k++) pow_d[32*k +: 32] = acc_q[k][WIN_LOG2 +: 32];
      mv_d   = 1'b1;
      wcnt_d = wcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!syn_rst_n) begin
      state_q   <= ST_IDLE;
      slot_q    <= '0;
      smp_q     <= '0;
      in_v_q    <= 1'b0;
      in_data_q <= '0;
      in_tag_q  <= '0;
      acc_q     <= '0;
      pub_q     <= 1'b0;
      pow_q     <= '0;
      mv_q      <= 1'b0;
      wcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      smp_q     <= smp_d;
      in_v_q    <= in_v_d;
      in_data_q <= in_data_d;
      in_tag_q  <= in_tag_d;
      acc_q     <= acc_d;
      pub_q     <= pub_d;
      pow_q     <= pow_d;
      mv_q      <= mv_d;
      wcnt_q    <= wcnt_d;
    end
  end

  assign o_pow        = pow_q;
  assign o_meas_valid = mv_q;
  assign o_win_cnt    = wcnt_q;
  assign o_busy       = (state_q == ST_ACC);

endmodule

// File: tb/tb_dl_ant_pow_meas.sv
// Directed bench for dl_ant_pow_meas with XNUM=4, WIN_LOG2=2 (16 samples per window).
module tb_dl_ant_pow_meas;
  import dl_path_pkg::*;

  localparam int XN = 4;
  localparam int WL = 2;
  localparam int NS = XN * (1 << WL);

  logic           clk = 1'b0;
  logic           syn_rst_n;
  logic           i_meas_en;
  logic           i_fram_hd;
  logic [31:0]    i_data;
  logic           i_data_valid;
  logic [XN*32-1:0] o_pow;
  logic           o_meas_valid;
  logic [15:0]    o_win_cnt;
  logic           o_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_edge = 0;

  logic [127:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [15:0]  exp_wc_q[$];
  logic [15:0]  exp_wc = '0;
  logic [127:0] last_exp = '0;
  logic [31:0]  win_data [NS];

  logic [127:0] mon_pow;
  int           mon_cyc;
  logic [15:0]  mon_wc;

  dl_ant_pow_meas #(
    .XNUM     (XN),
    .WIN_LOG2 (WL)
  ) dut (
    .clk          (clk),
    .syn_rst_n    (syn_rst_n),
    .i_meas_en    (i_meas_en),
    .i_fram_hd    (i_fram_hd),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_pow        (o_pow),
    .o_meas_valid (o_meas_valid),
    .o_win_cnt    (o_win_cnt),
    .o_busy       (o_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every publish must match the oldest pending window.
  always @(negedge clk) begin
    if (o_meas_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 128'd1, 128'd0);
      end else begin
        mon_pow = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        mon_wc  = exp_wc_q.pop_front();
        check("o_pow", o_pow, mon_pow);
        check("o_win_cnt", 128'(o_win_cnt), 128'(mon_wc));
        check("pulse_latency", 128'(cyc), 128'(mon_cyc));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic hd, input logic [31:0] d);
    i_data_valid = v;
    i_fram_hd    = hd;
    i_data       = d;
    @(posedge clk);
    #1;
    last_edge    = cyc;
    i_data_valid = 1'b0;
    i_fram_hd    = 1'b0;
  endtask

  function automatic longint sq(input logic [31:0] d);
    longint iv, qv;
    iv = $signed(d[31:16]);
    qv = $signed(d[15:0]);
    return iv * iv + qv * qv;
  endfunction

  task automatic run_window(input bit gaps, input bit hd0);
    longint       acc [XN];
    logic [127:0] e;
    for (int k = 0; k < XN; k++) acc[k] = 0;
    for (int j = 0; j < NS; j++) begin
      drive(1'b1, hd0 && (j == 0), win_data[j]);
      if (j == 0) check("busy_in_window", 128'(o_busy), 128'd1);
      acc[j % XN] += sq(win_data[j]);
      if (gaps && j != NS - 1) drive(1'b0, 1'b0, $urandom);
    end
    e = '0;
    for (int k = 0; k < XN; k++) e[32*k +: 32] = 32'(acc[k] >> WL);
    exp_wc = exp_wc + 16'd1;
    exp_q.push_back(e);
    exp_cyc_q.push_back(last_edge + POW_LAT);
    exp_wc_q.push_back(exp_wc);
    last_exp = e;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain", 128'(exp_q.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int j = 0; j < NS; j++) win_data[j] = $urandom;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    syn_rst_n    = 1'b0;
    i_meas_en    = 1'b0;
    i_fram_hd    = 1'b0;
    i_data_valid = 1'b0;
    i_data       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_pow", o_pow, 128'd0);
    check("rst_o_meas_valid", 128'(o_meas_valid), 128'd0);
    check("rst_o_win_cnt", 128'(o_win_cnt), 128'd0);
    check("rst_o_busy", 128'(o_busy), 128'd0);
    syn_rst_n = 1'b1;
    i_meas_en = 1'b1;

    // constant I=0x4000 on all antennas
    for (int j = 0; j < NS; j++) win_data[j] = 32'h4000_0000;
    run_window(1'b0, 1'b1);
    wait_drain();
    check("const_lane0", 128'(o_pow[31:0]), 128'h1000_0000);

    // per-antenna values with alternating signs
    for (int j = 0; j < NS; j++) begin
      case (j % XN)
        0:       win_data[j] = (j % 8 == 0) ? 32'h0100_0000 : 32'hFF00_0000;
        1:       win_data[j] = (j % 8 == 1) ? 32'h0000_0200 : 32'h0000_FE00;
        2:       win_data[j] = 32'h8000_8000;
        default: win_data[j] = 32'h0000_0000;
      endcase
    end
    run_window(1'b0, 1'b1);
    wait_drain();
    check("per_ant_lanes", o_pow, {32'h0, 32'h8000_0000, 32'h0004_0000, 32'h0001_0000});

    // truncated mean on antenna 0, other lanes random
    fill_random();
    win_data[0]  = 32'h0100_0000;
    win_data[4]  = 32'h0100_0000;
    win_data[8]  = 32'h0000_0000;
    win_data[12] = 32'h0000_0000;
    run_window(1'b0, 1'b1);
    wait_drain();
    check("mixed_lane0", 128'(o_pow[31:0]), 128'h0000_8000);

    // 1-0-1-0 valid toggling, same data as the constant case
    for (int j = 0; j < NS; j++) win_data[j] = 32'h4000_0000;
    run_window(1'b1, 1'b1);
    wait_drain();

    // frame head arriving on what would be the last window sample
    for (int j = 0; j < NS - 1; j++) drive(1'b1, j == 0, $urandom);
    check("abort_last_pow_held", o_pow, last_exp);
    fill_random();
    run_window(1'b0, 1'b1);
    wait_drain();

    // frame head reasserted at sample 9
    for (int j = 0; j < 9; j++) drive(1'b1, j == 0, $urandom);
    check("abort9_pow_held", o_pow, last_exp);
    fill_random();
    run_window(1'b0, 1'b1);
    wait_drain();

    // enable dropped mid-window
    drive(1'b1, 1'b1, $urandom);
    for (int j = 0; j < 5; j++) drive(1'b1, 1'b0, $urandom);
    check("en_busy_before", 128'(o_busy), 128'd1);
    i_meas_en = 1'b0;
    drive(1'b1, 1'b0, $urandom);
    check("en_busy_after", 128'(o_busy), 128'd0);
    for (int j = 0; j < 20; j++) drive(1'b1, (j % 7) == 0, $urandom);
    check("en_wcnt_held", 128'(o_win_cnt), 128'(exp_wc));
    check("en_pow_held", o_pow, last_exp);
    i_meas_en = 1'b1;
    for (int j = 0; j < NS; j++) drive(1'b1, 1'b0, $urandom);
    check("idle_no_head", 128'(o_busy), 128'd0);
    fill_random();
    run_window(1'b0, 1'b1);
    wait_drain();

    // reset pulse mid-window
    drive(1'b1, 1'b1, $urandom);
    for (int j = 0; j < 7; j++) drive(1'b1, 1'b0, $urandom);
    syn_rst_n = 1'b0;
    drive(1'b1, 1'b0, $urandom);
    syn_rst_n = 1'b1;
    check("midrst_o_pow", o_pow, 128'd0);
    check("midrst_o_win_cnt", 128'(o_win_cnt), 128'd0);
    check("midrst_o_meas_valid", 128'(o_meas_valid), 128'd0);
    check("midrst_o_busy", 128'(o_busy), 128'd0);
    exp_wc   = '0;
    last_exp = '0;
    for (int j = 0; j < NS + 8; j++) drive(1'b1, 1'b0, $urandom);
    check("postrst_idle", 128'(o_busy), 128'd0);
    check("postrst_pow", o_pow, 128'd0);
    fill_random();
    run_window(1'b0, 1'b1);
    wait_drain();
    check("postrst_wcnt", 128'(o_win_cnt), 128'd1);

    repeat (10) drive(1'b0, 1'b0, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
